// File: rtl/nf_pwm_pkg.sv
// Shared constants for the multi-channel AHB PWM: register offsets, CTRL bit
// positions, AHB encodings and the counting-mode enum.
package nf_pwm_pkg;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_PRESC    = 8'h04;
  localparam logic [7:0] REG_PERIOD   = 8'h08;
  localparam logic [7:0] REG_CNT      = 8'h0C;
  localparam logic [7:0] REG_STATUS   = 8'h10;
  localparam logic [7:0] REG_CMP_BASE = 8'h20;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_FORCE = 3;
  localparam int CTRL_INV   = 8;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_t;

endpackage

// File: rtl/nf_pwm_chan.sv
// One PWM compare channel: shadow/active compare pair, compare against the
// shared counter, and the registered polarity-adjusted output.
module nf_pwm_chan #(
  parameter int pwm_width = 16
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 shadow_wr,
  input  logic [pwm_width-1:0] wr_data,
  input  logic                 load,
  input  logic                 en,
  input  logic                 inv,
  input  logic [pwm_width-1:0] cnt,
  output logic [pwm_width-1:0] cmp_shadow,
  output logic                 pwm
);

  logic [pwm_width-1:0] cmp_shadow_reg;
  logic [pwm_width-1:0] cmp_shadow_next;
  logic [pwm_width-1:0] cmp_act_reg;
  logic                 pwm_reg;

  // A write landing on the load cycle must reach the active copy too.
  always_comb begin
    cmp_shadow_next = shadow_wr ? wr_data : cmp_shadow_reg;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cmp_shadow_reg <= '0;
      cmp_act_reg    <= '0;
      pwm_reg        <= 1'b0;
    end else begin
      cmp_shadow_reg <= cmp_shadow_next;
      if (load) begin
        cmp_act_reg <= cmp_shadow_next;
      end
      pwm_reg <= (en & (cnt < cmp_act_reg)) ^ inv;
    end
  end

  assign cmp_shadow = cmp_shadow_reg;
  assign pwm        = pwm_reg;

endmodule

// File: rtl/nf_ahb_pwm_mc.sv
// AHB-Lite multi-channel PWM: shared prescaler/period timebase (edge or center
// aligned), double-buffered PERIOD/CMP, period-end interrupt.
module nf_ahb_pwm_mc
  import nf_pwm_pkg::*;
#(
  parameter int pwm_width   = 16,
  parameter int pwm_chan    = 4,
  parameter int presc_width = 8
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic [31:0]         haddr_s,
  input  logic [31:0]         hwdata_s,
  output logic [31:0]         hrdata_s,
  input  logic                hwrite_s,
  input  logic [1:0]          htrans_s,
  input  logic [2:0]          hsize_s,
  input  logic [2:0]          hburst_s,
  output logic [1:0]          hresp_s,
  output logic                hready_s,
  input  logic                hsel_s,
  output logic [pwm_chan-1:0] pwm,
  output logic                pwm_irq
);

  localparam logic [pwm_width-1:0]   cnt_one   = 1;
  localparam logic [presc_width-1:0] presc_one = 1;

  logic                   act_reg;
  logic                   wr_reg;
  logic [5:0]             addr_reg;
  logic                   en_reg;
  logic                   ie_reg;
  pwm_mode_t              mode_reg;
  logic [pwm_chan-1:0]    inv_reg;
  logic [presc_width-1:0] presc_reg;
  logic [presc_width-1:0] presc_cnt_reg;
  logic [pwm_width-1:0]   period_sh_reg;
  logic [pwm_width-1:0]   period_sh_next;
  logic [pwm_width-1:0]   period_act_reg;
  logic [pwm_width-1:0]   cnt_reg;
  logic [pwm_width-1:0]   cnt_next;
  logic                   dir_down_reg;
  logic                   dir_down_next;
  logic                   pend_reg;

  logic [7:0]             ofs;
  logic                   wr_en;
  logic                   wr_ctrl;
  logic                   wr_presc;
  logic                   wr_period;
  logic                   wr_status;
  logic                   force_upd;
  logic                   tick;
  logic                   at_end;
  logic                   period_end;
  logic                   load_act;
  logic [31:0]            rd_data;
  logic [pwm_chan-1:0]    wr_cmp;
  logic [pwm_width-1:0]   cmp_sh [pwm_chan];
  logic [pwm_width-1:0]   cmp_rd [8];
  logic                   unused_bits;

  assign unused_bits = ^{haddr_s[31:8], haddr_s[1:0], hwdata_s, hsize_s, hburst_s};

  always_ff @(posedge hclk) begin
    if (hreset) begin
      act_reg  <= 1'b0;
      wr_reg   <= 1'b0;
      addr_reg <= '0;
    end else begin
      act_reg <= hsel_s & (htrans_s != HTRANS_IDLE);
      if (hsel_s & (htrans_s != HTRANS_IDLE)) begin
        addr_reg <= haddr_s[7:2];
        wr_reg   <= hwrite_s;
      end
    end
  end

  assign ofs       = {addr_reg, 2'b00};
  assign wr_en     = act_reg & wr_reg;
  assign wr_ctrl   = wr_en & (ofs == REG_CTRL);
  assign wr_presc  = wr_en & (ofs == REG_PRESC);
  assign wr_period = wr_en & (ofs == REG_PERIOD);
  assign wr_status = wr_en & (ofs == REG_STATUS);
  assign force_upd = wr_ctrl & hwdata_s[CTRL_FORCE];

  assign period_sh_next = wr_period ? hwdata_s[pwm_width-1:0] : period_sh_reg;

  // Prescaler uses >= so lowering PRESC below the running count cannot stall it.
  assign tick       = en_reg & (presc_cnt_reg >= presc_reg);
  assign at_end     = (period_act_reg == '0) ? 1'b1 :
                      (mode_reg == EDGE)     ? (cnt_reg >= period_act_reg) :
                                               ((cnt_reg == '0) & dir_down_reg);
  assign period_end = tick & at_end;
  assign load_act   = ~en_reg | force_upd | period_end;

  always_comb begin
    cnt_next      = cnt_reg;
    dir_down_next = dir_down_reg;
    if (period_act_reg == '0) begin
      cnt_next      = '0;
      dir_down_next = 1'b0;
    end else if (mode_reg == EDGE) begin
      cnt_next      = (cnt_reg >= period_act_reg) ? '0 : cnt_reg + cnt_one;
      dir_down_next = 1'b0;
    end else if (!dir_down_reg) begin
      // Turn at the peak without repeating it: PERIOD is followed by PERIOD-1.
      if (cnt_reg >= period_act_reg) begin
        cnt_next      = cnt_reg - cnt_one;
        dir_down_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + cnt_one;
      end
    end else begin
      if (cnt_reg == '0) begin
        cnt_next      = cnt_one;
        dir_down_next = 1'b0;
      end else begin
        cnt_next = cnt_reg - cnt_one;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      en_reg         <= 1'b0;
      ie_reg         <= 1'b0;
      mode_reg       <= EDGE;
      inv_reg        <= '0;
      presc_reg      <= '0;
      presc_cnt_reg  <= '0;
      period_sh_reg  <= '0;
      period_act_reg <= '0;
      cnt_reg        <= '0;
      dir_down_reg   <= 1'b0;
      pend_reg       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_reg   <= hwdata_s[CTRL_EN];
        mode_reg <= pwm_mode_t'(hwdata_s[CTRL_MODE]);
        ie_reg   <= hwdata_s[CTRL_IE];
        inv_reg  <= hwdata_s[CTRL_INV +: pwm_chan];
      end
      if (wr_presc) begin
        presc_reg <= hwdata_s[presc_width-1:0];
      end
      period_sh_reg <= period_sh_next;
      if (load_act) begin
        period_act_reg <= period_sh_next;
      end
      if (!en_reg || force_upd) begin
        presc_cnt_reg <= '0;
        cnt_reg       <= '0;
        dir_down_reg  <= 1'b0;
      end else if (tick) begin
        presc_cnt_reg <= '0;
        cnt_reg       <= cnt_next;
        dir_down_reg  <= dir_down_next;
      end else begin
        presc_cnt_reg <= presc_cnt_reg + presc_one;
      end
      // A period end in the same cycle as a software clear keeps PEND set.
      if (period_end) begin
        pend_reg <= 1'b1;
      end else if (wr_status & hwdata_s[0]) begin
        pend_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < pwm_chan; gi++) begin : g_chan
      localparam int cmp_idx = int'(REG_CMP_BASE >> 2) + gi;
      assign wr_cmp[gi] = wr_en & (addr_reg == 6'(cmp_idx));
      nf_pwm_chan #(.pwm_width(pwm_width)) u_chan (
        .clk        (hclk),
        .srst       (hreset),
        .shadow_wr  (wr_cmp[gi]),
        .wr_data    (hwdata_s[pwm_width-1:0]),
        .load       (load_act),
        .en         (en_reg),
        .inv        (inv_reg[gi]),
        .cnt        (cnt_reg),
        .cmp_shadow (cmp_sh[gi]),
        .pwm        (pwm[gi])
      );
    end
    for (gi = 0; gi < 8; gi++) begin : g_cmp_rd
      if (gi < pwm_chan) begin : g_used
        assign cmp_rd[gi] = cmp_sh[gi];
      end else begin : g_empty
        assign cmp_rd[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (addr_reg[5:3] == 3'b001) begin
      rd_data[pwm_width-1:0] = cmp_rd[addr_reg[2:0]];
    end else begin
      case (ofs)
        REG_CTRL: begin
          rd_data[CTRL_EN]              = en_reg;
          rd_data[CTRL_MODE]            = mode_reg;
          rd_data[CTRL_IE]              = ie_reg;
          rd_data[CTRL_INV +: pwm_chan] = inv_reg;
        end
        REG_PRESC:  rd_data[presc_width-1:0] = presc_reg;
        REG_PERIOD: rd_data[pwm_width-1:0]   = period_sh_reg;
        REG_CNT:    rd_data[pwm_width-1:0]   = cnt_reg;
        REG_STATUS: rd_data[0]               = pend_reg;
        default:    rd_data                  = '0;
      endcase
    end
  end

  assign hrdata_s = (act_reg & ~wr_reg) ? rd_data : 32'd0;
  assign hresp_s  = HRESP_OKAY;
  assign hready_s = 1'b1;
  assign pwm_irq  = pend_reg & ie_reg;

endmodule

// File: tb/tb_nf_ahb_pwm_mc.sv
// Directed self-checking bench for nf_ahb_pwm_mc (default parameters).
module tb_nf_ahb_pwm_mc;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr_s;
  logic [31:0] hwdata_s;
  logic [31:0] hrdata_s;
  logic        hwrite_s;
  logic [1:0]  htrans_s;
  logic [2:0]  hsize_s;
  logic [2:0]  hburst_s;
  logic [1:0]  hresp_s;
  logic        hready_s;
  logic        hsel_s;
  logic [3:0]  pwm;
  logic        pwm_irq;

  int total = 0;
  int bad   = 0;

  nf_ahb_pwm_mc dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .haddr_s  (haddr_s),
    .hwdata_s (hwdata_s),
    .hrdata_s (hrdata_s),
    .hwrite_s (hwrite_s),
    .htrans_s (htrans_s),
    .hsize_s  (hsize_s),
    .hburst_s (hburst_s),
    .hresp_s  (hresp_s),
    .hready_s (hready_s),
    .hsel_s   (hsel_s),
    .pwm      (pwm),
    .pwm_irq  (pwm_irq)
  );

  always #5 hclk = ~hclk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic bus_idle();
    hsel_s   = 1'b0;
    htrans_s = 2'b00;
    hwrite_s = 1'b0;
  endtask

  task automatic do_reset();
    bus_idle();
    haddr_s  = '0;
    hwdata_s = '0;
    hsize_s  = 3'b010;
    hburst_s = 3'b000;
    hreset   = 1'b1;
    step(3);
    hreset = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    hsel_s   = 1'b1;
    htrans_s = 2'b10;
    haddr_s  = a;
    hwrite_s = 1'b1;
    step(1);
    bus_idle();
    hwdata_s = d;
    step(1);
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    hsel_s   = 1'b1;
    htrans_s = 2'b10;
    haddr_s  = a;
    hwrite_s = 1'b0;
    step(1);
    bus_idle();
    d = hrdata_s;
    $display("read  addr=%h data=%h", a, d);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] addrs [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                                32'h20, 32'h24, 32'h28, 32'h2C};
    bus_idle();
    hreset = 1'b1;
    step(3);
    total++;
    if (pwm !== 4'b0000 || pwm_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_out pwm=%b irq=%b want pwm=0000 irq=0", pwm, pwm_irq);
    end
    total++;
    if (hready_s !== 1'b1 || hresp_s !== 2'b00) begin
      bad++;
      $display("FAIL reset_bus hready=%b hresp=%b want 1/00", hready_s, hresp_s);
    end
    hreset = 1'b0;
    foreach (addrs[i]) begin
      ahb_read(addrs[i], rd);
      total++;
      if (rd !== 32'd0) begin
        bad++;
        $display("FAIL reset_read addr=%h got=%h want=0", addrs[i], rd);
      end
    end
  endtask

  task automatic test_edge();
    int high0, high1, high2;
    logic [31:0] rd;
    do_reset();
    ahb_write(32'h04, 32'd0);
    ahb_write(32'h08, 32'd9);
    ahb_write(32'h20, 32'd3);
    ahb_write(32'h24, 32'd0);
    ahb_write(32'h28, 32'd15);
    ahb_write(32'h00, 32'h5);
    high0 = 0; high1 = 0; high2 = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      high0 += int'(pwm[0]);
      high1 += int'(pwm[1]);
      high2 += int'(pwm[2]);
      if (k == 9 || k == 10) begin
        total++;
        if (pwm_irq !== (k == 10)) begin
          bad++;
          $display("FAIL edge_irq cycle=%0d got=%b want=%b", k, pwm_irq, (k == 10));
        end
      end
    end
    $display("edge counts ch0=%0d ch1=%0d ch2=%0d", high0, high1, high2);
    total++;
    if (high0 != 6 || high1 != 0 || high2 != 20) begin
      bad++;
      $display("FAIL edge_duty got=%0d/%0d/%0d want=6/0/20", high0, high1, high2);
    end
    ahb_read(32'h0C, rd);
    total++;
    if (rd !== 32'd1) begin
      bad++;
      $display("FAIL edge_cnt got=%0d want=1", rd);
    end
  endtask

  task automatic test_center();
    int exp_cnt [16] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0};
    logic exp_pwm [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    ahb_write(32'h08, 32'd4);
    ahb_write(32'h20, 32'd2);
    ahb_write(32'h00, 32'h3);
    hsel_s   = 1'b1;
    htrans_s = 2'b10;
    haddr_s  = 32'h0C;
    hwrite_s = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      $display("center cycle=%0d cnt=%0d pwm0=%b", k, hrdata_s, pwm[0]);
      total++;
      if (hrdata_s !== 32'(exp_cnt[k-1]) || pwm[0] !== exp_pwm[k-1]) begin
        bad++;
        $display("FAIL center cycle=%0d cnt=%0d pwm0=%b want cnt=%0d pwm0=%b",
                 k, hrdata_s, pwm[0], exp_cnt[k-1], exp_pwm[k-1]);
      end
    end
    bus_idle();
  endtask

  task automatic test_double_buffer();
    logic [31:0] rd;
    logic        exp;
    do_reset();
    ahb_write(32'h08, 32'd9);
    ahb_write(32'h20, 32'd3);
    ahb_write(32'h00, 32'h1);
    step(3);
    ahb_write(32'h20, 32'd7);
    for (int k = 6; k <= 20; k++) begin
      step(1);
      exp = (k >= 11 && k <= 17);
      total++;
      if (pwm[0] !== exp) begin
        bad++;
        $display("FAIL dbuf cycle=%0d got=%b want=%b", k, pwm[0], exp);
      end
    end
    ahb_write(32'h20, 32'd2);
    ahb_write(32'h00, 32'h9);
    for (int j = 1; j <= 12; j++) begin
      step(1);
      exp = (j <= 2 || j >= 11);
      total++;
      if (pwm[0] !== exp) begin
        bad++;
        $display("FAIL force cycle=%0d got=%b want=%b", j, pwm[0], exp);
      end
    end
    ahb_read(32'h00, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL force_selfclear ctrl=%h want=00000001", rd);
    end
  endtask

  task automatic test_presc_irq();
    logic [31:0] rd;
    do_reset();
    ahb_write(32'h04, 32'd3);
    ahb_write(32'h08, 32'd1);
    ahb_write(32'h00, 32'h5);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      total++;
      if (pwm_irq !== (k == 8)) begin
        bad++;
        $display("FAIL presc_irq cycle=%0d got=%b want=%b", k, pwm_irq, (k == 8));
      end
    end
    ahb_write(32'h10, 32'h1);
    total++;
    if (pwm_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear got=%b want=0", pwm_irq);
    end
    step(4);
    ahb_write(32'h10, 32'h1);
    total++;
    if (pwm_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_set_wins got=%b want=1", pwm_irq);
    end
    ahb_read(32'h10, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL status_read got=%h want=00000001", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    do_reset();
    hsel_s   = 1'b1;
    htrans_s = 2'b10;
    haddr_s  = 32'h24;
    hwrite_s = 1'b1;
    step(1);
    hwdata_s = 32'h0000_ABCD;
    hwrite_s = 1'b0;
    step(1);
    bus_idle();
    $display("b2b read cmp1 data=%h", hrdata_s);
    total++;
    if (hrdata_s !== 32'h0000_ABCD) begin
      bad++;
      $display("FAIL b2b_cmp1 got=%h want=0000abcd", hrdata_s);
    end
    ahb_write(32'h08, 32'hFFFF_1234);
    ahb_read(32'h08, rd);
    total++;
    if (rd !== 32'h0000_1234) begin
      bad++;
      $display("FAIL period_trunc got=%h want=00001234", rd);
    end
    ahb_write(32'h1C, 32'hFFFF_FFFF);
    ahb_read(32'h1C, rd);
    total++;
    if (rd !== 32'd0) begin
      bad++;
      $display("FAIL unmapped got=%h want=0", rd);
    end
    ahb_write(32'h0C, 32'h55);
    ahb_read(32'h0C, rd);
    total++;
    if (rd !== 32'd0) begin
      bad++;
      $display("FAIL cnt_readonly got=%h want=0", rd);
    end
  endtask

  task automatic test_polarity();
    logic [31:0] rd;
    do_reset();
    ahb_write(32'h00, 32'h800);
    step(1);
    total++;
    if (pwm !== 4'b1000) begin
      bad++;
      $display("FAIL inv3 pwm=%b want=1000", pwm);
    end
    ahb_read(32'h00, rd);
    total++;
    if (rd !== 32'h800) begin
      bad++;
      $display("FAIL ctrl_read got=%h want=00000800", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    do_reset();
    ahb_write(32'h08, 32'd9);
    ahb_write(32'h20, 32'd5);
    ahb_write(32'h00, 32'h1);
    step(4);
    total++;
    if (pwm[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_running pwm0=%b want=1", pwm[0]);
    end
    hreset = 1'b1;
    step(1);
    hreset = 1'b0;
    total++;
    if (pwm !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_out pwm=%b want=0000", pwm);
    end
    step(3);
    ahb_read(32'h0C, rd);
    total++;
    if (rd !== 32'd0 || pwm !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_hold cnt=%0d pwm=%b want cnt=0 pwm=0000", rd, pwm);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_double_buffer();
    test_presc_irq();
    test_back_to_back();
    test_polarity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
